// File: rtl/tt_um_buzzer_monitor_if.sv
// Pin bundle of the buzzer monitor: enable, input byte and output byte.
// The stimulus side owns ena/ui; the monitor drives uo.
interface tt_um_buzzer_monitor_if;
  logic       ena;
  logic [7:0] ui;
  logic [7:0] uo;

  modport master (output ena, output ui, input uo);
  modport slave  (input ena, input ui, output uo);
endinterface

// File: rtl/tt_um_buzzer_monitor.sv
// Buzzer pulse monitor: checks single-line pulses on three lines for width and overlap,
// counts valid pulses per line and exposes counts/flags through a selectable nibble.
//
// state  | meaning
// IDLE   | all lines low, waiting for a rise
// ACTIVE | one line high, measuring its width
// FAULT  | overlap seen, waiting for all lines low
module tt_um_buzzer_monitor #(
  parameter int WMIN = 24,
  parameter int WMAX = 40
) (
  input  logic                        clk,
  input  logic                        rst_n,
  tt_um_buzzer_monitor_if.slave       bus
);

  localparam logic [5:0] LP_WMIN = 6'(WMIN);
  localparam logic [5:0] LP_WMAX = 6'(WMAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_s;
  logic [5:0] r_w;
  logic [5:0] w_w_nxt;
  logic [1:0] r_ch;
  logic [1:0] w_ch_nxt;
  logic [3:0] r_cnt1;
  logic [3:0] r_cnt2;
  logic [3:0] r_cnt3;
  logic [1:0] r_last_ch;
  logic       r_width_err;
  logic       r_overlap_err;
  logic       r_strobe;

  logic       w_onehot;
  logic [1:0] w_enc;
  logic [2:0] w_ch_mask;
  logic       w_valid;
  logic       w_set_werr;
  logic       w_set_oerr;
  logic       w_clr;
  logic [3:0] w_nib;
  logic       w_unused;

  assign w_clr    = bus.ui[5];
  assign w_unused = &{1'b0, bus.ui[7:6]};

  always_comb begin
    w_onehot = 1'b0;
    w_enc    = 2'd0;
    case (r_s)
      3'b001: begin w_onehot = 1'b1; w_enc = 2'd1; end
      3'b010: begin w_onehot = 1'b1; w_enc = 2'd2; end
      3'b100: begin w_onehot = 1'b1; w_enc = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    case (r_ch)
      2'd1:    w_ch_mask = 3'b001;
      2'd2:    w_ch_mask = 3'b010;
      2'd3:    w_ch_mask = 3'b100;
      default: w_ch_mask = 3'b000;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_w_nxt     = r_w;
    w_ch_nxt    = r_ch;
    w_valid     = 1'b0;
    w_set_werr  = 1'b0;
    w_set_oerr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_s != 3'b000) begin
          if (w_onehot) begin
            w_state_nxt = ST_ACTIVE;
            w_ch_nxt    = w_enc;
            w_w_nxt     = 6'd1;
          end else begin
            w_state_nxt = ST_FAULT;
            w_set_oerr  = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        // A foreign line wins over the latched line's own level.
        if ((r_s & ~w_ch_mask) != 3'b000) begin
          w_state_nxt = ST_FAULT;
          w_set_oerr  = 1'b1;
        end else if ((r_s & w_ch_mask) != 3'b000) begin
          if (r_w != 6'd63) w_w_nxt = r_w + 6'd1;
        end else begin
          w_state_nxt = ST_IDLE;
          if (r_w >= LP_WMIN && r_w <= LP_WMAX) w_valid = 1'b1;
          else                                  w_set_werr = 1'b1;
        end
      end
      ST_FAULT: begin
        if (r_s == 3'b000) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s     <= 3'b000;
      r_state <= ST_IDLE;
      r_w     <= 6'd0;
      r_ch    <= 2'd0;
    end else if (bus.ena) begin
      r_s     <= bus.ui[2:0];
      r_state <= w_state_nxt;
      r_w     <= w_w_nxt;
      r_ch    <= w_ch_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt1        <= 4'd0;
      r_cnt2        <= 4'd0;
      r_cnt3        <= 4'd0;
      r_last_ch     <= 2'd0;
      r_width_err   <= 1'b0;
      r_overlap_err <= 1'b0;
      r_strobe      <= 1'b0;
    end else if (bus.ena) begin
      // Clear beats a same-cycle event or flag set, but the strobe still fires.
      if (w_clr) begin
        r_cnt1        <= 4'd0;
        r_cnt2        <= 4'd0;
        r_cnt3        <= 4'd0;
        r_last_ch     <= 2'd0;
        r_width_err   <= 1'b0;
        r_overlap_err <= 1'b0;
      end else begin
        if (w_valid) begin
          r_last_ch <= r_ch;
          case (r_ch)
            2'd1:    if (r_cnt1 != 4'hF) r_cnt1 <= r_cnt1 + 4'd1;
            2'd2:    if (r_cnt2 != 4'hF) r_cnt2 <= r_cnt2 + 4'd1;
            2'd3:    if (r_cnt3 != 4'hF) r_cnt3 <= r_cnt3 + 4'd1;
            default: ;
          endcase
        end
        if (w_set_werr) r_width_err   <= 1'b1;
        if (w_set_oerr) r_overlap_err <= 1'b1;
      end
      r_strobe <= w_valid;
    end
  end

  always_comb begin
    case (bus.ui[4:3])
      2'd0:    w_nib = r_cnt1;
      2'd1:    w_nib = r_cnt2;
      2'd2:    w_nib = r_cnt3;
      default: w_nib = {r_last_ch, r_width_err, r_overlap_err};
    endcase
  end

  assign bus.uo = {1'b0,
                   r_width_err | r_overlap_err,
                   (r_state != ST_IDLE),
                   r_strobe & bus.ena,
                   w_nib};

endmodule

// File: doc/tt_um_buzzer_monitor.md
TT_UM_BUZZER_MONITOR -- requirements
Module: tt_um_buzzer_monitor

Interface
REQ-001 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous and active-low; it clears all state immediately when low.
REQ-003 SHALL have port ena  input  1  enable; when low, all registers hold their value (reset still acts).
REQ-004 SHALL have port ui  input  8  ui[2:0] buzzer lines 1..3 under monitor; ui[4:3] readout select; ui[5] synchronous clear; ui[7:6] unused.
REQ-005 SHALL have port uo  output  8  uo[3:0] readout nibble; uo[4] event strobe; uo[5] busy; uo[6] sticky error; uo[7] constant 0.
REQ-006 SHALL use parameter WMIN, default 24, meaning minimum valid pulse width in cycles.
REQ-007 SHALL use parameter WMAX, default 40, meaning maximum valid pulse width in cycles.

Function
REQ-008 SHALL register ui[2:0] once into s[2:0] every enabled cycle; all decisions use s, not ui.
REQ-009 SHALL implement FSM states IDLE, ACTIVE, FAULT.
REQ-010 IDLE: s == 000 stays IDLE; exactly one bit of s high -> ACTIVE, latch channel ch (1..3), width W = 1; two or more bits high -> FAULT, set overlap_err.
REQ-011 ACTIVE: s[ch] high and other bits low -> W = W + 1, saturating at 63 (6-bit).
REQ-012 ACTIVE: any non-latched bit high -> FAULT, set overlap_err, no count update, regardless of s[ch].
REQ-013 ACTIVE: s[ch] low and others low -> IDLE; if WMIN <= W <= WMAX, the event is valid, else set width_err.
REQ-014 Valid event SHALL increment cnt[ch] (4-bit, saturating at 15), set last_ch = ch, and assert uo[4] for exactly one cycle on the cycle after the falling edge is seen in s.
REQ-015 FAULT: stays until s == 000, then -> IDLE; no events counted while in FAULT.
REQ-016 uo[5] (busy) SHALL be high exactly while the FSM is in ACTIVE or FAULT.
REQ-017 uo[6] SHALL equal width_err OR overlap_err; both are sticky until clear or reset.
REQ-018 Readout select 0/1/2 SHALL drive uo[3:0] = cnt1/cnt2/cnt3; select 3 SHALL drive {last_ch[1:0], width_err, overlap_err}; readout is combinational from registers.
REQ-019 ui[5] high on an enabled cycle SHALL zero cnt1..3, last_ch, width_err, overlap_err at the next edge; the FSM and W are unaffected.
REQ-020 If clear and a valid event coincide, clear SHALL win: counts read 0 and last_ch 0; uo[4] still pulses.
REQ-021 If clear and an error flag-set coincide, clear SHALL win.
REQ-022 ena low SHALL freeze s, FSM, W, counters, flags; uo[4] SHALL be 0 while ena is low.

Reset
REQ-023 While rst_n is low: s = 000, FSM = IDLE, W = 0, cnt1..3 = 0, last_ch = 0, both error flags = 0, uo = 0x00 (with select 0).
REQ-024 Reset asserted mid-ACTIVE SHALL discard the pulse in progress; after release, a line still high SHALL be treated as a new rise (W restarts at 1).

Verification
REQ-025 Line 2 high 31 cycles, others low -> one uo[4] pulse after the fall; select 1 reads 0001; select 3 reads 1000.
REQ-026 Line 1 high 10 cycles, then separately 50 cycles -> no uo[4], cnt1 = 0, select 3 reads 0010, uo[6] = 1.
REQ-027 Line 3 pulse (31 cycles) with line 1 rising at cycle 5 -> FAULT, busy until both low, overlap_err = 1, cnt3 = 0.
REQ-028 Seventeen valid 31-cycle pulses on line 1 -> cnt1 saturates at 1111; ui[5] one cycle -> all nibbles 0000, uo[6] = 0.
REQ-029 Pulses of exactly 24 and 40 cycles counted; pulses of 23 and 41 cycles set width_err only.
REQ-030 rst_n low at cycle 15 of a 31-cycle pulse, released at cycle 20 -> remaining 11 high cycles form W = 11, width_err set, no count.
